// File: rtl/seg7_mux_capture_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_mux_capture_if                                           |
// | Purpose  : Bundles the multiplexed seven-segment link pins and the       |
// |            decoded results of the capture block.                         |
// | Signals  : seg_in[6:0]    segment bus, bit0=a .. bit6=g (active high)    |
// |            sel_in[1:0]    digit select, 10=digit0, 01=digit1             |
// |            digit0/digit1  last accepted low/high nibble                  |
// |            digit_upd[1:0] per-digit write pulse                          |
// |            frame_valid    both digits accepted since last frame          |
// |            bad_pattern    non-decodable pattern accepted                 |
// |            err_count[7:0] saturating count of bad patterns               |
// |            stale          no valid digit for the timeout period          |
// | Modports : master drives the link pins, slave is the capture block.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface seg7_mux_capture_if;
  logic [6:0] seg_in;
  logic [1:0] sel_in;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [1:0] digit_upd;
  logic       frame_valid;
  logic       bad_pattern;
  logic [7:0] err_count;
  logic       stale;

  modport master (
    output seg_in, sel_in,
    input  digit0, digit1, digit_upd, frame_valid, bad_pattern, err_count, stale
  );

  modport slave (
    input  seg_in, sel_in,
    output digit0, digit1, digit_upd, frame_valid, bad_pattern, err_count, stale
  );
endinterface
`default_nettype wire

// File: rtl/seg7_mux_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg7_mux_capture                                              |
// | Purpose  : Receiving end of a two-digit multiplexed seven-segment link.  |
// |            Synchronises the pins, waits for a stable dwell, decodes the  |
// |            segment pattern to a hex nibble and rebuilds the two-digit    |
// |            value. Flags illegal patterns and loss of link.               |
// | Ports    : CLOCK_50  system clock, rising edge                           |
// |            reset     synchronous active-high reset                       |
// |            bus       seg7_mux_capture_if.slave (pins in, results out)    |
// | Params   : STABLE_CYCLES  identical samples needed to accept (2..255)    |
// |            TIMEOUT_CYCLES idle cycles before stale asserts (2..2^24)     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module seg7_mux_capture #(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  wire logic          CLOCK_50,
  input  wire logic          reset,
  seg7_mux_capture_if.slave  bus
);

  localparam logic [7:0]  c_CNT_MAX = 8'(STABLE_CYCLES - 1);
  // One bit wider than the nominal 24-bit timer so a timeout of exactly
  // 2^24 is still reachable; the timer parks at the timeout value.
  localparam logic [24:0] c_TIMEOUT = 25'(TIMEOUT_CYCLES);

  typedef enum logic [0:0] {
    ST_TRACK = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  // Pin pair packed as {sel[1:0], seg[6:0]}
  logic [8:0]  r_sync1;
  logic [8:0]  r_sync2;
  logic [8:0]  r_prev;
  logic [7:0]  r_cnt;
  state_t      r_state;
  logic [1:0]  r_seen;
  logic [24:0] r_timer;
  logic [3:0]  r_digit0;
  logic [3:0]  r_digit1;
  logic [1:0]  r_upd;
  logic        r_frame;
  logic        r_bad;
  logic [7:0]  r_err;
  logic        r_stale;

  logic        w_changed;
  logic        w_accept;
  logic [1:0]  w_sel;
  logic [6:0]  w_seg;
  logic        w_valid_sel;
  logic        w_blank;
  logic        w_legal;
  logic [3:0]  w_nib;
  logic        w_good;
  logic        w_bad;
  logic        w_dsel;
  logic [1:0]  w_dmask;
  logic [1:0]  w_seen_set;
  logic [24:0] w_timer_nxt;

  // ------------------------------------------------------------------
  // Synchroniser and stability counter
  // ------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= {bus.sel_in, bus.seg_in};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      if (w_changed) begin
        r_cnt <= '0;
      end else if (r_cnt != c_CNT_MAX) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  assign w_changed = (r_sync2 != r_prev);

  // The counter only reaches its maximum while TRACKing at the end of a
  // fresh dwell, so this fires exactly once per dwell. The accepted value
  // is r_prev, which is the pattern that was held stable.
  assign w_accept = (r_state == ST_TRACK) && (r_cnt == c_CNT_MAX);

  assign w_sel       = r_prev[8:7];
  assign w_seg       = r_prev[6:0];
  assign w_valid_sel = (w_sel == 2'b10) || (w_sel == 2'b01);
  assign w_blank     = !w_valid_sel || (w_seg == 7'h00);
  assign w_good      = w_accept && !w_blank && w_legal;
  assign w_bad       = w_accept && !w_blank && !w_legal;
  assign w_dsel      = (w_sel == 2'b01);
  assign w_dmask     = w_dsel ? 2'b10 : 2'b01;
  assign w_seen_set  = r_seen | w_dmask;

  // ------------------------------------------------------------------
  // Segment pattern to nibble
  // ------------------------------------------------------------------
  always_comb begin
    w_nib   = 4'h0;
    w_legal = 1'b1;
    case (w_seg)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_legal = 1'b0;
    endcase
  end

  // Timer clears only on a valid digit; otherwise counts up and parks.
  always_comb begin
    w_timer_nxt = r_timer;
    if (w_good) begin
      w_timer_nxt = '0;
    end else if (r_timer != c_TIMEOUT) begin
      w_timer_nxt = r_timer + 25'd1;
    end
  end

  // ------------------------------------------------------------------
  // Acceptance FSM with registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state  <= ST_TRACK;
      r_seen   <= 2'b00;
      r_timer  <= '0;
      r_digit0 <= 4'h0;
      r_digit1 <= 4'h0;
      r_upd    <= 2'b00;
      r_frame  <= 1'b0;
      r_bad    <= 1'b0;
      r_err    <= 8'h00;
      r_stale  <= 1'b0;
    end else begin
      r_upd   <= 2'b00;
      r_frame <= 1'b0;
      r_bad   <= 1'b0;
      r_timer <= w_timer_nxt;
      r_stale <= (w_timer_nxt == c_TIMEOUT);

      case (r_state)
        ST_TRACK: begin
          if (w_accept) begin
            // A pin change on the acceptance cycle already starts the next
            // dwell, so stay in TRACK rather than parking in HOLD.
            r_state <= w_changed ? ST_TRACK : ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_changed) begin
            r_state <= ST_TRACK;
          end
        end
        default: r_state <= ST_TRACK;
      endcase

      if (w_good) begin
        if (w_dsel) begin
          r_digit1 <= w_nib;
        end else begin
          r_digit0 <= w_nib;
        end
        r_upd <= w_dmask;
        if (w_seen_set == 2'b11) begin
          r_frame <= 1'b1;
          r_seen  <= 2'b00;
        end else begin
          r_seen  <= w_seen_set;
        end
      end

      if (w_bad) begin
        r_bad <= 1'b1;
        if (r_err != 8'hFF) begin
          r_err <= r_err + 8'd1;
        end
      end
    end
  end

  assign bus.digit0      = r_digit0;
  assign bus.digit1      = r_digit1;
  assign bus.digit_upd   = r_upd;
  assign bus.frame_valid = r_frame;
  assign bus.bad_pattern = r_bad;
  assign bus.err_count   = r_err;
  assign bus.stale       = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_seg7_mux_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seg7_mux_capture                                           |
// | Purpose  : Self-checking bench for seg7_mux_capture. A behavioural       |
// |            model counts runs of identical pin samples, accepts a run     |
// |            three edges after it reaches STABLE_CYCLES samples and        |
// |            applies the digit/frame/error/timeout rules to it.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_seg7_mux_capture;

  localparam int S = 16;
  localparam int T = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg7_mux_capture_if bus ();

  seg7_mux_capture #(
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus)
  );

  int vectors    = 0;
  int miscompares = 0;

  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Behavioural model state
  bit         armed = 0;
  logic [3:0] m_d0, m_d1;
  logic [1:0] m_upd, m_seen;
  logic       m_fv, m_bad, m_stale;
  int         m_err, m_idle;
  logic [8:0] run_val;
  int         run_len;
  bit         pv [3];
  logic [8:0] pval [3];

  // Observations gathered while holding pins
  int edge_no = 0;
  int last_upd_edge = 0, stale_rise_edge = -1, stale_fall_edge = -1;
  logic prev_stale = 1'b0;
  int h_first, h_upd, h_fv, h_fv_first, h_bad;

  function automatic int lookup(input logic [6:0] s);
    int r;
    r = -1;
    for (int k = 0; k < 16; k++) if (tbl[k] == s) r = k;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [8:0] smp;
    logic [1:0] sel;
    logic [6:0] seg;
    bit         acc_v, good;
    logic [8:0] acc_p;
    int         idx;
    smp = {bus.sel_in, bus.seg_in};
    if (rst) begin
      armed = 1;
      m_d0 = 0; m_d1 = 0; m_upd = 0; m_seen = 0;
      m_fv = 0; m_bad = 0; m_stale = 0; m_err = 0; m_idle = 0;
      // Synchroniser and history are all zero: the zero run already
      // spans three samples at the reset edge.
      run_val = '0; run_len = 3;
      for (int k = 0; k < 3; k++) begin pv[k] = 0; pval[k] = '0; end
      return;
    end
    acc_v = pv[2]; acc_p = pval[2];
    pv[2] = pv[1]; pval[2] = pval[1];
    pv[1] = pv[0]; pval[1] = pval[0];
    m_upd = 0; m_fv = 0; m_bad = 0; good = 0;
    if (acc_v) begin
      sel = acc_p[8:7]; seg = acc_p[6:0];
      if ((sel == 2'b10 || sel == 2'b01) && seg != 7'h00) begin
        idx = lookup(seg);
        if (idx < 0) begin
          m_bad = 1;
          if (m_err < 255) m_err++;
        end else begin
          good = 1;
          if (sel == 2'b01) begin m_d1 = 4'(idx); m_upd = 2'b10; m_seen[1] = 1; end
          else              begin m_d0 = 4'(idx); m_upd = 2'b01; m_seen[0] = 1; end
          if (m_seen == 2'b11) begin m_fv = 1; m_seen = 0; end
        end
      end
    end
    if (good) m_idle = 0; else if (m_idle < T) m_idle++;
    m_stale = (m_idle >= T);
    if (smp == run_val) begin
      if (run_len <= S) run_len++;
    end else begin
      run_val = smp; run_len = 1;
    end
    pv[0] = (run_len == S); pval[0] = run_val;
  endtask

  task automatic check_all();
    if (!armed) return;
    chk("digit0",      32'(bus.digit0),      32'(m_d0));
    chk("digit1",      32'(bus.digit1),      32'(m_d1));
    chk("digit_upd",   32'(bus.digit_upd),   32'(m_upd));
    chk("frame_valid", 32'(bus.frame_valid), 32'(m_fv));
    chk("bad_pattern", 32'(bus.bad_pattern), 32'(m_bad));
    chk("err_count",   32'(bus.err_count),   32'(m_err));
    chk("stale",       32'(bus.stale),       32'(m_stale));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    edge_no++;
    @(negedge clk);
    check_all();
    if (bus.digit_upd != 2'b00) last_upd_edge = edge_no;
    if (bus.stale && !prev_stale) stale_rise_edge = edge_no;
    if (!bus.stale && prev_stale) stale_fall_edge = edge_no;
    prev_stale = bus.stale;
  endtask

  // Drive pins and hold them for n edges; index 0 is the first edge that
  // samples the new values.
  task automatic hold(input logic [1:0] sel, input logic [6:0] seg, input int n);
    bus.sel_in = sel; bus.seg_in = seg;
    h_first = -1; h_upd = 0; h_fv = 0; h_fv_first = -1; h_bad = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus.digit_upd != 2'b00) begin h_upd++; if (h_first < 0) h_first = i; end
      if (bus.frame_valid) begin h_fv++; if (h_fv_first < 0) h_fv_first = i; end
      if (bus.bad_pattern) h_bad++;
    end
  endtask

  initial begin
    int g_upd, g_bad, len, pick;
    logic [1:0] rs;
    logic [6:0] rg;
    bus.sel_in = 2'b00; bus.seg_in = 7'h00;

    // Reset state
    rst = 1'b1;
    hold(2'b00, 7'h00, 3);
    rst = 1'b0;
    chk("rst_digit0", 32'(bus.digit0), 32'd0);
    chk("rst_err",    32'(bus.err_count), 32'd0);

    // Single digit, acceptance latency
    hold(2'b10, 7'h5B, 40);
    chk("lat_first_upd", 32'(h_first), 32'd18);
    chk("lat_upd_count", 32'(h_upd), 32'd1);
    chk("lat_digit0",    32'(bus.digit0), 32'd2);
    chk("lat_no_frame",  32'(h_fv), 32'd0);

    // Alternating digits build frames
    for (int p = 0; p < 3; p++) begin
      hold(2'b10, 7'h4F, 100);
      chk("alt_d0_nofv", 32'(h_fv), 32'd0);
      hold(2'b01, 7'h66, 100);
      chk("alt_fv_count", 32'(h_fv), 32'd1);
      chk("alt_fv_align", 32'(h_fv_first), 32'(h_first));
    end
    chk("alt_digit0", 32'(bus.digit0), 32'd3);
    chk("alt_digit1", 32'(bus.digit1), 32'd4);

    // Bad pattern and saturation
    hold(2'b01, 7'h55, 30);
    chk("bad_pulses", 32'(h_bad), 32'd1);
    chk("bad_err1",   32'(bus.err_count), 32'd1);
    chk("bad_digit1", 32'(bus.digit1), 32'd4);
    for (int r = 0; r < 300; r++) begin
      hold(2'b00, 7'h00, 20);
      hold(2'b01, 7'h55, 20);
    end
    chk("bad_sat", 32'(bus.err_count), 32'd255);

    // Short glitches are ignored
    g_upd = 0; g_bad = 0;
    for (int r = 0; r < 6; r++) begin
      hold(2'b10, 7'h06, 5); g_upd += h_upd; g_bad += h_bad;
      hold(2'b10, 7'h07, 5); g_upd += h_upd; g_bad += h_bad;
    end
    chk("glitch_upd", 32'(g_upd), 32'd0);
    chk("glitch_bad", 32'(g_bad), 32'd0);
    hold(2'b10, 7'h06, 40);
    chk("glitch_clean_d0", 32'(bus.digit0), 32'd1);

    // Link-loss timeout
    hold(2'b01, 7'h3F, 30);
    stale_rise_edge = -1;
    hold(2'b00, 7'h00, 70);
    chk("stale_level", 32'(bus.stale), 32'd1);
    chk("stale_rise", 32'(stale_rise_edge - last_upd_edge), 32'(T));
    hold(2'b10, 7'h7F, 30);
    chk("stale_fall", 32'(stale_fall_edge), 32'(last_upd_edge));
    chk("stale_clear", 32'(bus.stale), 32'd0);

    // Reset mid-dwell (stability counter at 10)
    hold(2'b01, 7'h6D, 13);
    chk("mid_no_upd", 32'(h_upd), 32'd0);
    rst = 1'b1;
    hold(2'b01, 7'h6D, 1);
    rst = 1'b0;
    chk("mid_rst_d0",  32'(bus.digit0), 32'd0);
    chk("mid_rst_d1",  32'(bus.digit1), 32'd0);
    chk("mid_rst_err", 32'(bus.err_count), 32'd0);
    hold(2'b01, 7'h6D, 40);
    chk("mid_first_upd", 32'(h_first), 32'd18);
    chk("mid_digit1",    32'(bus.digit1), 32'd5);

    // Randomised dwells against the model
    for (int r = 0; r < 200; r++) begin
      rs   = 2'($urandom_range(0, 3));
      pick = int'($urandom_range(0, 9));
      if (pick < 6)       rg = tbl[$urandom_range(0, 15)];
      else if (pick == 6) rg = 7'h00;
      else                rg = 7'($urandom);
      len = int'($urandom_range(1, 40));
      hold(rs, rg, len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
